// File: rtl/alu_input_sequencer_if.sv
// alu_input_sequencer_if: switch/button inputs, ALU operand/opcode outputs and result feedback for the sequencer
//   i_sw        slide switches, low bits are the value loaded
//   i_btn       raw push buttons: [0] load A, [1] load B, [2] load opcode
//   i_resultado combinational ALU result
//   o_dato_a, o_dato_b, o_operador  registered ALU inputs
//   o_leds, o_valid                 latched result and its one-cycle update pulse
//   o_estado                        FSM state for debug LEDs
interface alu_input_sequencer_if #(
    parameter int NB_DATA     = 8,
    parameter int NB_OPERADOR = 6,
    parameter int NB_SW       = 8
);
    logic [NB_SW-1:0]       i_sw;
    logic [2:0]             i_btn;
    logic [NB_DATA-1:0]     i_resultado;
    logic [NB_DATA-1:0]     o_dato_a;
    logic [NB_DATA-1:0]     o_dato_b;
    logic [NB_OPERADOR-1:0] o_operador;
    logic [NB_DATA-1:0]     o_leds;
    logic                   o_valid;
    logic [1:0]             o_estado;
    modport master (
        output i_sw, i_btn, i_resultado,
        input  o_dato_a, o_dato_b, o_operador, o_leds, o_valid, o_estado
    );
    modport slave (
        input  i_sw, i_btn, i_resultado,
        output o_dato_a, o_dato_b, o_operador, o_leds, o_valid, o_estado
    );
endinterface

// File: rtl/alu_input_sequencer.sv
// alu_input_sequencer: debounces three load buttons and steps A -> B -> opcode -> execute, latching the ALU result
//   i_clk, i_reset  clock and synchronous active-high reset
//   bus             alu_input_sequencer_if.slave: switches, buttons, ALU result in; operands, opcode, LEDs, valid, state out
module alu_input_sequencer #(
    parameter int NB_DATA         = 8,
    parameter int NB_OPERADOR     = 6,
    parameter int NB_SW           = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input logic                  i_clk,
    input logic                  i_reset,
    alu_input_sequencer_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    typedef enum logic [1:0] {WAIT_A = 2'b00, WAIT_B = 2'b01, WAIT_OP = 2'b10, EXEC = 2'b11} state_t;
    state_t                 state_q;
    logic [2:0]             sync1_q, sync2_q, deb_q, deb_dly_q, pulse;
    logic [CW-1:0]          cnt_q [3];
    logic [NB_DATA-1:0]     dato_a_q, dato_b_q, leds_q;
    logic [NB_OPERADOR-1:0] operador_q;
    logic                   valid_q;
    // one pulse per accepted rising edge of the debounced level
    assign pulse = deb_q & ~deb_dly_q;
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q   <= bus.i_btn;
            sync2_q   <= sync1_q;
            deb_dly_q <= deb_q;
            // a level change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] != deb_q[i]) begin
                    if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                        deb_q[i] <= sync2_q[i];
                        cnt_q[i] <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + CW'(1);
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= WAIT_A;
            dato_a_q   <= '0;
            dato_b_q   <= '0;
            operador_q <= '0;
            leds_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            // only the pulse matching the current state is acted on; others are dropped
            case (state_q)
                WAIT_A: if (pulse[0]) begin
                    dato_a_q <= bus.i_sw[NB_DATA-1:0];
                    state_q  <= WAIT_B;
                end
                WAIT_B: if (pulse[1]) begin
                    dato_b_q <= bus.i_sw[NB_DATA-1:0];
                    state_q  <= WAIT_OP;
                end
                WAIT_OP: if (pulse[2]) begin
                    operador_q <= bus.i_sw[NB_OPERADOR-1:0];
                    state_q    <= EXEC;
                end
                EXEC: begin
                    leds_q  <= bus.i_resultado;
                    valid_q <= 1'b1;
                    state_q <= WAIT_A;
                end
                default: state_q <= WAIT_A;
            endcase
        end
    end
    assign bus.o_dato_a   = dato_a_q;
    assign bus.o_dato_b   = dato_b_q;
    assign bus.o_operador = operador_q;
    assign bus.o_leds     = leds_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_estado   = state_q;
endmodule

// File: doc/alu_input_sequencer.md
Name: alu_input_sequencer

Overview:
- Upstream operand/opcode loader for the combinational ALU, inside the board-level ALU top.
- Captures operand A, operand B and the 6-bit funct opcode from slide switches using three push buttons.
- Each button is synchronised and debounced before use.
- Drives the ALU inputs from registers, then latches the ALU's combinational result into a registered LED output.

Parameters:
- NB_DATA, 8, operand and result width (must match the ALU).
- NB_OPERADOR, 6, opcode width (must match the ALU).
- NB_SW, 8, switch bus width; must be >= NB_DATA and >= NB_OPERADOR.
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a button level change; minimum 1.

Ports:
- i_clk  in  1  system clock; all state changes on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_sw  in  NB_SW  slide switches; the low bits are the value loaded.
- i_btn  in  3  raw, asynchronous push buttons: [0] load A, [1] load B, [2] load opcode.
- i_resultado  in  NB_DATA  combinational result returned from the ALU.
- o_dato_a  out  NB_DATA  registered operand A to the ALU.
- o_dato_b  out  NB_DATA  registered operand B to the ALU.
- o_operador  out  NB_OPERADOR  registered opcode to the ALU.
- o_leds  out  NB_DATA  latched result.
- o_valid  out  1  one-cycle pulse when o_leds is updated.
- o_estado  out  2  current FSM state, for debug LEDs.

Behaviour:
- Reset (synchronous, active-high): clears o_dato_a, o_dato_b, o_operador, o_leds, o_valid, all synchroniser flops, debounced levels, their delayed copies and debounce counters. FSM enters WAIT_A. Reset has priority over everything, including mid-sequence and mid-debounce.
- Per button, independent path:
  - 2-flop synchroniser, giving sync.
  - Debounced level deb and counter cnt, updated each edge:
    - if sync != deb: if cnt == DEBOUNCE_CYCLES-1, then deb <= sync and cnt <= 0; else cnt <= cnt+1.
    - if sync == deb: cnt <= 0.
  - Press pulse = deb & ~deb_q, where deb_q is deb registered one cycle.
- Latency: the button is first sampled high at edge k. deb rises at edge k+1+DEBOUNCE_CYCLES. The pulse is high during the following cycle and is consumed at edge k+2+DEBOUNCE_CYCLES.
- Glitches: any high or low excursion shorter than DEBOUNCE_CYCLES cycles after synchronisation produces no pulse and does not change deb.
- Holding a button produces exactly one pulse. Release produces no pulse.
- A button held through reset release produces one pulse, DEBOUNCE_CYCLES+2 edges after reset deasserts.
- FSM states and o_estado encoding:
  - WAIT_A (00): pulse[0] loads o_dato_a <= i_sw[NB_DATA-1:0], then go to WAIT_B.
  - WAIT_B (01): pulse[1] loads o_dato_b <= i_sw[NB_DATA-1:0], then go to WAIT_OP.
  - WAIT_OP (10): pulse[2] loads o_operador <= i_sw[NB_OPERADOR-1:0], then go to EXEC.
  - EXEC (11): lasts exactly one cycle with ALU inputs stable. At its closing edge, o_leds <= i_resultado and o_valid <= 1 for one cycle. Next state is WAIT_A.
- Out-of-order or unexpected pulses in any state are ignored: no register change, no state change.
- Simultaneous pulses: only the one expected by the current state is acted on; the others are discarded, not queued.
- Pulses arriving during EXEC are ignored.
- o_leds holds its value until the next EXEC.
- o_dato_a, o_dato_b and o_operador hold their values until reloaded. A new A load does not clear B or the opcode.
- i_sw may change at any time; only the value present at the loading edge is captured.
- No arithmetic in this block. Widths are truncated to the low bits of i_sw.

Test Plan:
- Reset then idle: all outputs 0, o_estado = 00. Hold i_reset high for 3 cycles mid-sequence (in WAIT_OP) -> all registers 0 and state 00 the cycle after the reset edge.
- Full sequence, DEBOUNCE_CYCLES = 4:
  - sw = 8'h05 + btn[0]; sw = 8'h03 + btn[1]; sw = 8'h20 (ADD) + btn[2]; stub ALU returns a+b.
  - -> o_dato_a = 5 exactly 6 edges after btn[0] is first sampled high.
  - -> o_leds = 8'h08 with a one-cycle o_valid pulse at the edge after entering EXEC; o_estado back to 00.
- Debounce filter: btn[0] high for 3 cycles then low -> no load, o_estado stays 00. Held high for 40 cycles -> exactly one load.
- Order enforcement: in WAIT_A press btn[1] and btn[2] -> no change. Press btn[0] and btn[2] in the same cycle -> only A loads, state goes to 01.
- Repeat run: second sequence A = 8'hF0, B = 8'h0F, op = 6'b100110 (XOR), stub XOR -> o_leds = 8'hFF. First result held until that EXEC.
- Switch change: i_sw toggles every cycle around the load edge -> the captured value equals i_sw at the consuming edge (k+2+DEBOUNCE_CYCLES).
